// File: rtl/regfile_dump.sv
// Walks register file indices 0..NUM_REGS-1 onto a valid/ready stream; REGFILE_DUMP_CHECKSUM_EN appends an XOR word.
// Latency: first word valid two edges after start is raised; one word per 2 cycles when the sink never stalls.
// Backpressure: a word is held stable while out_ready is low; abort or reset_n drops the dump without a done pulse.
module regfile_dump #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 5,
  parameter int NUM_REGS = 17
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  output logic [REG_BITS-1:0] rd_index,
  input  logic [WIDTH-1:0]    rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [REG_BITS-1:0] out_index,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_CSUM, S_DONE} state_e;
  localparam logic [REG_BITS-1:0] CSUM_IDX = REG_BITS'(NUM_REGS);
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_e;
`endif

  localparam logic [REG_BITS-1:0] LAST_IDX = REG_BITS'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [REG_BITS-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [REG_BITS-1:0] out_index_q, out_index_d;
  logic                hs;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0]    csum_q, csum_d;
`endif

  assign hs = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          idx_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        out_data_d  = rd_data;
        out_index_d = idx_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_d      = csum_q ^ rd_data;
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // csum_q already folds in the last word, captured during its FETCH
            out_data_d  = csum_q;
            out_index_d = CSUM_IDX;
            state_d     = S_CSUM;
`else
            state_d     = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (hs) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rd_index  = idx_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
`ifdef REGFILE_DUMP_CHECKSUM_EN
  assign out_valid = (state_q == S_SEND) || (state_q == S_CSUM);
  assign out_last  = (state_q == S_CSUM);
`else
  assign out_valid = (state_q == S_SEND);
  assign out_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: directed dump scenarios plus randomized contents/backpressure against a word-list model.
// Latency: n/a. Backpressure: out_ready driven per cycle by the bench.
module tb_regfile_dump;
  localparam int WIDTH    = 16;
  localparam int REG_BITS = 5;
  localparam int NUM_REGS = 17;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n, start, abort, out_ready;
  logic [REG_BITS-1:0] rd_index, out_index;
  logic [WIDTH-1:0]    rd_data, out_data;
  logic                out_valid, out_last, busy, done;
  logic [WIDTH-1:0]    rf [0:(1<<REG_BITS)-1];

  typedef struct {
    logic [WIDTH-1:0] data;
    int               index;
    bit               last;
  } word_t;
  word_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  assign rd_data = rf[rd_index];

  regfile_dump #(.WIDTH(WIDTH), .REG_BITS(REG_BITS), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rd_index(rd_index), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: every register in order, then the XOR of all of them when the checksum is built in.
  task automatic build_expected();
    word_t w;
    logic [WIDTH-1:0] x;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      w.data = rf[i]; w.index = i; w.last = !CSUM_ON && (i == NUM_REGS - 1);
      exp_q.push_back(w);
      x = x ^ rf[i];
    end
    if (CSUM_ON) begin
      w.data = x; w.index = NUM_REGS; w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic idle_zero(input string tag);
    chk(tag, {out_valid, busy, done, out_last, out_data, out_index, rd_index}, 32'd0);
  endtask

  task automatic run_dump(input int ready_pct, input int hold_idx, input int restart_idx,
                          input int abort_idx, input bit check_timing);
    int words = 0;
    int dones = 0;
    int done_k = -1;
    int first_k = -1;
    int holds = 0;
    bit prev_stall = 1'b0;
    bit aborted = 1'b0;
    logic [WIDTH-1:0] pd;
    logic [REG_BITS-1:0] pi;
    logic pl;
    build_expected();
    start = 1'b1;
    tick();
    for (int k = 0; k < 400; k++) begin
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      if (prev_stall) begin
        chk("stall_data", out_data, pd);
        chk("stall_index", out_index, pi);
        chk("stall_last", out_last, pl);
      end
      if (done) begin
        dones++;
        done_k = k;
      end
      if (out_valid) begin
        chk("valid_implies_busy", busy, 1'b1);
        if (first_k < 0) first_k = k;
        if (abort_idx >= 0 && out_index == REG_BITS'(abort_idx)) begin
          abort = 1'b1; out_ready = 1'b1;
          tick();
          abort = 1'b0; out_ready = 1'b0;
          chk("abort_busy", busy, 1'b0);
          chk("abort_valid", out_valid, 1'b0);
          chk("abort_done", done, 1'b0);
          aborted = 1'b1;
          break;
        end
        if (restart_idx >= 0 && out_index == REG_BITS'(restart_idx)) start = 1'b1;
        if (hold_idx >= 0 && out_index == REG_BITS'(hold_idx) && holds < 5) begin
          holds++;
          chk("hold_data", out_data, rf[hold_idx]);
          chk("hold_index", out_index, hold_idx);
        end else begin
          out_ready = ($urandom_range(99) < ready_pct);
        end
        if (out_ready) begin
          if (words < exp_q.size()) begin
            chk("word_data", out_data, exp_q[words].data);
            chk("word_index", out_index, exp_q[words].index);
            chk("word_last", out_last, exp_q[words].last);
          end else begin
            chk("extra_word", words, exp_q.size());
          end
          words++;
        end
        prev_stall = !out_ready;
        pd = out_data; pi = out_index; pl = out_last;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        tick();
        break;
      end
      tick();
    end
    start = 1'b0; out_ready = 1'b0;
    if (!aborted) begin
      chk("word_count", words, exp_q.size());
      chk("done_count", dones, 1);
      chk("done_one_cycle", done, 1'b0);
      chk("idle_after_done", busy, 1'b0);
      if (check_timing) begin
        chk("first_valid_latency", first_k, 1);
        chk("start_to_done", done_k, 2 * NUM_REGS + (CSUM_ON ? 1 : 0));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < (1 << REG_BITS); i++) rf[i] = WIDTH'($urandom);
    for (int i = 0; i < NUM_REGS; i++) rf[i] = (i == 0) ? 16'h0000 : 16'h1000 + 16'(i);
    #12;
    idle_zero("reset_state");
    reset_n = 1'b1;
    tick();
    idle_zero("idle_after_reset");

    run_dump(100, -1, -1, -1, 1'b1);
    run_dump(100, 3, -1, -1, 1'b0);
    run_dump(100, -1, 5, -1, 1'b1);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_with_abort_ignored", busy, 1'b0);
    tick();
    chk("still_idle", busy, 1'b0);

    run_dump(100, -1, -1, 8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_done_after_abort", {done, busy, out_valid}, 3'b000);
    end
    run_dump(100, -1, -1, -1, 1'b1);

    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("send_before_reset", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    idle_zero("async_reset");
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      idle_zero("quiet_after_reset");
    end
    run_dump(100, -1, -1, -1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < (1 << REG_BITS); i++) rf[i] = WIDTH'($urandom);
      run_dump(55, -1, -1, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
